gr8ram_dram_sched: RTL and testbench



---
 rtl/gr8ram_dram_sched.sv | 194 +++++++++++++++++++
 tb/tb_gr8ram_dram_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gr8ram_dram_sched.sv
// gr8ram_dram_sched: DRAM cycle sequencer/arbiter for the GR8RAM card.
// Tracks the Apple II bus phase as a C7M-rate state counter S. It shares the
// DRAM between slot accesses (S4..S6) and CBR refresh (S1..S3), and it drives
// every RAS/CAS/ASel strobe from registers.
// Optional feature: define GR8RAM_REF_BURST_EN to let an idle access slot run
// a second CBR refresh whenever refreshes are still owed.
module gr8ram_dram_sched #(
    parameter int REF_INTERVAL = 13,  // S1 entries per owed refresh (2..255)
    parameter int REF_MAX_PEND = 4    // owed-refresh saturation (1..7)
) (
    input  logic       C7M,
    input  logic       nRES,
    input  logic       PHI1,
    input  logic       req,
    input  logic       wr,
    input  logic       bank,
    output logic       nRAS,
    output logic       nCAS0,
    output logic       nCAS1,
    output logic       ASel,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [2:0] ref_pend
);

    // Bus-phase states; 0 means not yet synchronised to PHI1.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S1     = 3'd1;
    localparam logic [2:0] S2     = 3'd2;
    localparam logic [2:0] S3     = 3'd3;
    localparam logic [2:0] S4     = 3'd4;
    localparam logic [2:0] S5     = 3'd5;
    localparam logic [2:0] S6     = 3'd6;
    localparam logic [2:0] S7     = 3'd7;

    // Which DRAM cycle owns the current slot.
    localparam logic [1:0] SLOT_NONE  = 2'd0;
    localparam logic [1:0] SLOT_REF   = 2'd1;
    localparam logic [1:0] SLOT_ACC   = 2'd2;
    localparam logic [1:0] SLOT_BURST = 2'd3;

    localparam logic [7:0] TICK_LAST = 8'(REF_INTERVAL - 1);
    localparam logic [2:0] PEND_MAX  = 3'(REF_MAX_PEND);

    logic [2:0] s, s_nx;
    logic       phi1_q, phi0seen, sync, late;
    logic [7:0] tick, tick_nx;
    logic       tick_wrap, ref_take, burst_take;
    logic [2:0] pend_nx;
    logic [1:0] slot, slot_nx;
    logic       acc_wr, acc_bank, acc_wr_nx, acc_bank_nx;
    logic       ras_nx, cas0_nx, cas1_nx, asel_nx, busy_nx, done_nx, abort_nx;
    logic       acc_cas;

    // Next-state logic: phase tracking, refresh bookkeeping, slot choice.
    always_comb begin
        sync = PHI1 & ~phi1_q & phi0seen;
        late = (s >= S4) && (s <= S6);

        if (sync)              s_nx = S1;
        else if (s == S_IDLE)  s_nx = S_IDLE;
        else if (s == S7)      s_nx = S7;
        else                   s_nx = s + 3'd1;

        tick_nx   = tick;
        tick_wrap = 1'b0;
        if (sync) begin
            if (tick == TICK_LAST) begin
                tick_nx   = 8'd0;
                tick_wrap = 1'b1;
            end else begin
                tick_nx = tick + 8'd1;
            end
        end

        // A resync that cuts S4..S6 short skips this S1 refresh; it stays owed.
        ref_take = sync && !late && (ref_pend != 3'd0);
`ifdef GR8RAM_REF_BURST_EN
        burst_take = !sync && (s == S3) && !req && (ref_pend != 3'd0);
`else
        burst_take = 1'b0;
`endif

        pend_nx = ref_pend;
        if (tick_wrap && !ref_take) begin
            if (ref_pend != PEND_MAX) pend_nx = ref_pend + 3'd1;
        end else if (!tick_wrap && (ref_take || burst_take)) begin
            pend_nx = ref_pend - 3'd1;
        end

        slot_nx     = slot;
        acc_wr_nx   = acc_wr;
        acc_bank_nx = acc_bank;
        if (sync) begin
            slot_nx = ref_take ? SLOT_REF : SLOT_NONE;
        end else if (s == S3) begin
            if (req) begin
                slot_nx     = SLOT_ACC;
                acc_wr_nx   = wr;
                acc_bank_nx = bank;
            end else if (burst_take) begin
                slot_nx = SLOT_BURST;
            end else begin
                slot_nx = SLOT_NONE;
            end
        end else if (s_nx == S7) begin
            slot_nx = SLOT_NONE;
        end

        done_nx  = !sync && (s == S6) && (slot == SLOT_ACC);
        abort_nx = sync && (slot == SLOT_ACC);
    end

    // Strobe decode from the next state so registered pins line up with S.
    always_comb begin
        ras_nx  = 1'b1;
        cas0_nx = 1'b1;
        cas1_nx = 1'b1;
        asel_nx = 1'b0;
        acc_cas = 1'b0;
        busy_nx = (slot_nx != SLOT_NONE);
        case (slot_nx)
            SLOT_REF: begin
                if (s_nx == S1 || s_nx == S2) begin
                    cas0_nx = 1'b0;
                    cas1_nx = 1'b0;
                end
                if (s_nx == S2 || s_nx == S3) ras_nx = 1'b0;
            end
            SLOT_ACC: begin
                if (s_nx >= S4 && s_nx <= S6) ras_nx = 1'b0;
                asel_nx = (s_nx == S5) || (s_nx == S6);
                // Writes use late CAS so data is valid before the strobe.
                acc_cas = acc_wr_nx ? (s_nx == S6) : ((s_nx == S5) || (s_nx == S6));
                if (acc_bank_nx) cas1_nx = ~acc_cas;
                else             cas0_nx = ~acc_cas;
            end
            SLOT_BURST: begin
                if (s_nx == S4 || s_nx == S5) begin
                    cas0_nx = 1'b0;
                    cas1_nx = 1'b0;
                end
                if (s_nx == S5 || s_nx == S6) ras_nx = 1'b0;
            end
            default: ;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            s        <= S_IDLE;
            phi1_q   <= 1'b0;
            phi0seen <= 1'b0;
            tick     <= 8'd0;
            ref_pend <= 3'd0;
            slot     <= SLOT_NONE;
            acc_wr   <= 1'b0;
            acc_bank <= 1'b0;
        end else begin
            s        <= s_nx;
            phi1_q   <= PHI1;
            phi0seen <= phi0seen | ~PHI1;
            tick     <= tick_nx;
            ref_pend <= pend_nx;
            slot     <= slot_nx;
            acc_wr   <= acc_wr_nx;
            acc_bank <= acc_bank_nx;
        end
    end

    // Registered DRAM pins and status pulses.
    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            nRAS    <= 1'b1;
            nCAS0   <= 1'b1;
            nCAS1   <= 1'b1;
            ASel    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            nRAS    <= ras_nx;
            nCAS0   <= cas0_nx;
            nCAS1   <= cas1_nx;
            ASel    <= asel_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            aborted <= abort_nx;
        end
    end

endmodule

// File: tb/tb_gr8ram_dram_sched.sv
// Scoreboard bench for gr8ram_dram_sched: a bus-cycle-level model pushes the
// expected pin state for every clock, and a negedge monitor pops and compares.
module tb_gr8ram_dram_sched;

    localparam int REF_INTERVAL = 13;
    localparam int REF_MAX_PEND = 4;

    localparam int K_NONE  = 0;
    localparam int K_REF   = 1;
    localparam int K_ACC   = 2;
    localparam int K_BURST = 3;

    logic       C7M = 1'b0;
    logic       nRES = 1'b0;
    logic       PHI1 = 1'b0;
    logic       req = 1'b0;
    logic       wr = 1'b0;
    logic       bank = 1'b0;
    logic       nRAS, nCAS0, nCAS1, ASel, busy, done, aborted;
    logic [2:0] ref_pend;

    typedef struct packed {
        logic       nras;
        logic       ncas0;
        logic       ncas1;
        logic       asel;
        logic       busy;
        logic       done;
        logic       aborted;
        logic [2:0] pend;
    } obs_t;

    obs_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (bus-cycle view)
    int m_s = 0, m_tick = 0, m_pend = 0, m_kind = K_NONE;
    bit m_prev = 0, m_seen = 0, m_wr = 0, m_bank = 0;

    gr8ram_dram_sched #(.REF_INTERVAL(REF_INTERVAL), .REF_MAX_PEND(REF_MAX_PEND)) dut (
        .C7M(C7M), .nRES(nRES), .PHI1(PHI1), .req(req), .wr(wr), .bank(bank),
        .nRAS(nRAS), .nCAS0(nCAS0), .nCAS1(nCAS1), .ASel(ASel), .busy(busy),
        .done(done), .aborted(aborted), .ref_pend(ref_pend)
    );

    always #5 C7M = ~C7M;

    // Pin waveform for the current bus state, from the slot timing tables.
    function automatic obs_t expect_out(bit dn, bit ab);
        obs_t o;
        bit   on;
        o.nras = 1; o.ncas0 = 1; o.ncas1 = 1; o.asel = 0;
        o.busy = (m_kind != K_NONE); o.done = dn; o.aborted = ab;
        o.pend = 3'(m_pend);
        if (m_kind == K_REF) begin
            if (m_s == 1 || m_s == 2) begin o.ncas0 = 0; o.ncas1 = 0; end
            if (m_s == 2 || m_s == 3) o.nras = 0;
        end else if (m_kind == K_ACC) begin
            o.nras = 0;
            o.asel = (m_s == 5 || m_s == 6);
            on = m_wr ? (m_s == 6) : (m_s == 5 || m_s == 6);
            if (m_bank) o.ncas1 = !on; else o.ncas0 = !on;
        end else if (m_kind == K_BURST) begin
            if (m_s == 4 || m_s == 5) begin o.ncas0 = 0; o.ncas1 = 0; end
            if (m_s == 5 || m_s == 6) o.nras = 0;
        end
        return o;
    endfunction

    task automatic model_step();
        bit rise, dn, ab, inc, dec;
        rise = PHI1 && !m_prev && m_seen;
        if (!PHI1) m_seen = 1;
        m_prev = PHI1;
        dn = 0; ab = 0;
        if (rise) begin
            ab  = (m_kind == K_ACC);
            dec = !(m_s >= 4 && m_s <= 6) && (m_pend > 0);
            inc = (m_tick == REF_INTERVAL - 1);
            m_tick = inc ? 0 : m_tick + 1;
            m_pend = m_pend + int'(inc) - int'(dec);
            if (m_pend > REF_MAX_PEND) m_pend = REF_MAX_PEND;
            m_kind = dec ? K_REF : K_NONE;
            m_s = 1;
        end else if (m_s != 0) begin
            if (m_s == 3) begin
                if (req) begin
                    m_kind = K_ACC; m_wr = wr; m_bank = bank;
                end else begin
                    m_kind = K_NONE;
`ifdef GR8RAM_REF_BURST_EN
                    if (m_pend >= 1) begin m_kind = K_BURST; m_pend = m_pend - 1; end
`endif
                end
            end
            if (m_s == 6 && m_kind == K_ACC) dn = 1;
            if (m_s < 7) m_s = m_s + 1;
            if (m_s == 7) m_kind = K_NONE;
        end
        expq.push_back(expect_out(dn, ab));
    endtask

    // Model advances on the same edge as the DUT; reset drops all history.
    always @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            m_s = 0; m_tick = 0; m_pend = 0; m_kind = K_NONE;
            m_prev = 0; m_seen = 0; m_wr = 0; m_bank = 0;
            expq.delete();
        end else begin
            model_step();
        end
    end

    // Monitor: compare DUT pins against the oldest expectation each cycle.
    always @(negedge C7M) begin
        if (nRES && expq.size() > 0) begin
            obs_t e, a;
            e = expq.pop_front();
            a = {nRAS, nCAS0, nCAS1, ASel, busy, done, aborted, ref_pend};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL pins t=%0t got ras=%b cas0=%b cas1=%b asel=%b busy=%b done=%b abort=%b pend=%0d want ras=%b cas0=%b cas1=%b asel=%b busy=%b done=%b abort=%b pend=%0d",
                         $time, a.nras, a.ncas0, a.ncas1, a.asel, a.busy, a.done, a.aborted, a.pend,
                         e.nras, e.ncas0, e.ncas1, e.asel, e.busy, e.done, e.aborted, e.pend);
            end
        end
    end

    task automatic check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge C7M);
        #3;
    endtask

    // One bus cycle: PHI1 high for hi clocks, then low for lo clocks.
    task automatic bus(int hi, int lo, bit r, bit w, bit b);
        req = r; wr = w; bank = b;
        PHI1 = 1'b1;
        repeat (hi) step();
        PHI1 = 1'b0;
        repeat (lo) step();
    endtask

    initial begin
        repeat (3) step();
        check("rst_nRAS", nRAS, 1);
        check("rst_nCAS0", nCAS0, 1);
        check("rst_nCAS1", nCAS1, 1);
        check("rst_ASel", ASel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_ref_pend", ref_pend, 0);
        nRES = 1'b1;

        // Idle bus: refresh accrues and is served at the following S1.
        repeat (16) bus(7, 7, 0, 0, 0);
        // Read from bank 1, write to bank 0.
        bus(7, 7, 1, 0, 1);
        bus(7, 7, 1, 1, 0);
        bus(7, 7, 1, 0, 0);
        // Read cut short by a PHI1 rise at S5.
        bus(2, 3, 1, 0, 1);
        bus(7, 7, 0, 0, 0);
        // Repeated early resyncs: refreshes keep being owed and saturate.
        repeat (70) bus(2, 3, 1, 0, 0);
        check("pend_saturated", ref_pend, REF_MAX_PEND);
        // Normal cycles drain the backlog (two per cycle with burst refresh).
        repeat (6) bus(7, 7, 0, 0, 0);

        // Reset in the middle of a read: strobes release at once.
        req = 1'b1; wr = 1'b0; bank = 1'b1; PHI1 = 1'b1;
        repeat (5) step();
        check("mid_read_nRAS", nRAS, 0);
        check("mid_read_nCAS1", nCAS1, 0);
        nRES = 1'b0;
        #1;
        check("async_rst_nRAS", nRAS, 1);
        check("async_rst_nCAS1", nCAS1, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_pend", ref_pend, 0);
        step();
        nRES = 1'b1;
        repeat (3) step();
        PHI1 = 1'b0;
        repeat (4) step();

        // Random bus timing and requests.
        for (int i = 0; i < 200; i++) begin
            bus(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)),
                1'($urandom), 1'($urandom), 1'($urandom));
        end
        bus(7, 7, 0, 0, 0);

        @(negedge C7M);
        #1;
        check("scoreboard_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
